rgb_sequencer_pwm: RTL and testbench

Parametrised successor to the board's fixed 6-colour RGB blinker.
- Drives the active-low RGB LED through per-channel PWM.
- Three modes: hard-step colour cycle, smooth hue-wheel fade, and manual step.
- Debounced BOOT and SW buttons select pause/advance and mode.
- Sits directly between the board pins and the 12 MHz clock domain.

---
 rtl/rgb_sequencer_pwm.sv | 272 +++++++++++++++++++++++++++
 tb/tb_rgb_sequencer_pwm.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rgb_sequencer_pwm.sv
// rgb_sequencer_pwm
//
// Colour sequencer for the board's active-low RGB LED. Each channel is driven by
// PWM from a shared free-running counter. Three modes are supported:
//   STEP   - hard colour steps R, RG, G, GB, B, RB, one every STEP_CYCLES clocks
//   FADE   - smooth hue wheel: one channel ramps per segment, one ramp step every
//            FADE_TICK clocks, 2^PWM_BITS ramp steps per segment
//   MANUAL - no timers; BOOT steps through the STEP-mode colours
// The BOOT and SW buttons are active-low, asynchronous to clk, synchronised and
// debounced. An SW press cycles the mode. A BOOT press toggles pause in STEP/FADE
// and advances the colour in MANUAL.
//
// Ports:
//   clk    in   system clock (12 MHz)
//   rst_n  in   asynchronous active-low reset
//   BOOT   in   raw button, active-low
//   SW     in   raw button, active-low
//   RGB_R  out  red LED, active-low (0 = lit), registered
//   RGB_G  out  green LED, active-low, registered
//   RGB_B  out  blue LED, active-low, registered

module rgb_sequencer_pwm #(
   parameter int unsigned STEP_CYCLES     = 12000000,
   parameter int unsigned FADE_TICK       = 46875,
   parameter int unsigned PWM_BITS        = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic BOOT,
   input  logic SW,
   output logic RGB_R,
   output logic RGB_G,
   output logic RGB_B
);

   localparam int unsigned StepW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int unsigned FadeW = (FADE_TICK > 1) ? $clog2(FADE_TICK) : 1;
   localparam int unsigned DebW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   localparam logic [StepW-1:0]    StepLast = StepW'(STEP_CYCLES - 1);
   localparam logic [FadeW-1:0]    FadeLast = FadeW'(FADE_TICK - 1);
   localparam logic [DebW-1:0]     DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] DutyMax  = '1;
   localparam logic [2:0]          IdxLast  = 3'd5;

   // Button vector index
   localparam int unsigned BtnBoot = 0;
   localparam int unsigned BtnSw   = 1;

   typedef enum logic [1:0] {
      StStep,
      StFade,
      StManual
   } mode_e;

   // ---------------------------------------------------------------------------
   // Button synchronisers and debouncers
   // ---------------------------------------------------------------------------
   logic [1:0]     btn_meta_q;
   logic [1:0]     btn_sync_q;
   logic [1:0]     btn_deb_q;
   logic [1:0]     btn_deb_d;
   logic [1:0]     btn_press;
   logic [DebW-1:0] deb_cnt_q [2];
   logic [DebW-1:0] deb_cnt_d [2];

   // Synchroniser and debounce state resets to "released" so a button held
   // through reset still has to pass the full debounce interval.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_meta_q <= 2'b11;
         btn_sync_q <= 2'b11;
         btn_deb_q  <= 2'b11;
         for (int i = 0; i < 2; i++) begin
            deb_cnt_q[i] <= '0;
         end
      end else begin
         btn_meta_q <= {SW, BOOT};
         btn_sync_q <= btn_meta_q;
         btn_deb_q  <= btn_deb_d;
         for (int i = 0; i < 2; i++) begin
            deb_cnt_q[i] <= deb_cnt_d[i];
         end
      end
   end

   // The counter runs only while the synced level disagrees with the accepted
   // level; any agreeing cycle (a bounce) restarts it. The press pulse fires in
   // the cycle the new low level is accepted.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         btn_deb_d[i] = btn_deb_q[i];
         deb_cnt_d[i] = '0;
         btn_press[i] = 1'b0;
         if (btn_sync_q[i] != btn_deb_q[i]) begin
            if (deb_cnt_q[i] == DebLast) begin
               btn_deb_d[i] = btn_sync_q[i];
               btn_press[i] = ~btn_sync_q[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
            end
         end
      end
   end

   logic boot_press;
   logic sw_press;

   assign boot_press = btn_press[BtnBoot];
   assign sw_press   = btn_press[BtnSw];

   // ---------------------------------------------------------------------------
   // Mode / colour sequencer
   // ---------------------------------------------------------------------------
   mode_e              mode_q, mode_d;
   logic [2:0]         idx_q, idx_d;
   logic               paused_q, paused_d;
   logic [StepW-1:0]   step_q, step_d;
   logic [FadeW-1:0]   fade_q, fade_d;
   logic [PWM_BITS-1:0] ramp_q, ramp_d;
   logic [2:0]         idx_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q   <= StStep;
         idx_q    <= '0;
         paused_q <= 1'b0;
         step_q   <= '0;
         fade_q   <= '0;
         ramp_q   <= '0;
      end else begin
         mode_q   <= mode_d;
         idx_q    <= idx_d;
         paused_q <= paused_d;
         step_q   <= step_d;
         fade_q   <= fade_d;
         ramp_q   <= ramp_d;
      end
   end

   assign idx_next = (idx_q == IdxLast) ? 3'd0 : idx_q + 3'd1;

   always_comb begin
      mode_d   = mode_q;
      idx_d    = idx_q;
      paused_d = paused_q;
      step_d   = step_q;
      fade_d   = fade_q;
      ramp_d   = ramp_q;

      // Timed advance; pause freezes timers and ramp but not the PWM.
      unique case (mode_q)
         StStep: begin
            if (!paused_q) begin
               if (step_q == StepLast) begin
                  step_d = '0;
                  idx_d  = idx_next;
               end else begin
                  step_d = step_q + StepW'(1);
               end
            end
         end
         StFade: begin
            if (!paused_q) begin
               if (fade_q == FadeLast) begin
                  fade_d = '0;
                  if (ramp_q == DutyMax) begin
                     ramp_d = '0;
                     idx_d  = idx_next;
                  end else begin
                     ramp_d = ramp_q + PWM_BITS'(1);
                  end
               end else begin
                  fade_d = fade_q + FadeW'(1);
               end
            end
         end
         default: begin
         end
      endcase

      // SW outranks BOOT when both presses land in the same cycle.
      if (sw_press) begin
         unique case (mode_q)
            StStep:  mode_d = StFade;
            StFade:  mode_d = StManual;
            default: mode_d = StStep;
         endcase
         idx_d    = idx_q;
         paused_d = 1'b0;
         step_d   = '0;
         fade_d   = '0;
         ramp_d   = '0;
      end else if (boot_press) begin
         if (mode_q == StManual) begin
            idx_d = idx_next;
         end else begin
            paused_d = ~paused_q;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Duty selection
   // ---------------------------------------------------------------------------
   logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;
   logic [PWM_BITS-1:0] ramp_inv;

   // ramp_q never exceeds DutyMax, so this cannot underflow.
   assign ramp_inv = DutyMax - ramp_q;

   always_comb begin
      duty_r = '0;
      duty_g = '0;
      duty_b = '0;
      if (mode_q == StFade) begin
         case (idx_q)
            3'd0: begin duty_r = DutyMax;  duty_g = ramp_q;   end
            3'd1: begin duty_r = ramp_inv; duty_g = DutyMax;  end
            3'd2: begin duty_g = DutyMax;  duty_b = ramp_q;   end
            3'd3: begin duty_g = ramp_inv; duty_b = DutyMax;  end
            3'd4: begin duty_r = ramp_q;   duty_b = DutyMax;  end
            3'd5: begin duty_r = DutyMax;  duty_b = ramp_inv; end
            default: begin
            end
         endcase
      end else begin
         case (idx_q)
            3'd0: begin duty_r = DutyMax;                    end
            3'd1: begin duty_r = DutyMax; duty_g = DutyMax;  end
            3'd2: begin duty_g = DutyMax;                    end
            3'd3: begin duty_g = DutyMax; duty_b = DutyMax;  end
            3'd4: begin duty_b = DutyMax;                    end
            3'd5: begin duty_r = DutyMax; duty_b = DutyMax;  end
            default: begin
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // PWM and registered active-low outputs
   // ---------------------------------------------------------------------------
   logic [PWM_BITS-1:0] pwm_cnt_q;
   logic                lit_r, lit_g, lit_b;
   logic                rgb_r_q, rgb_g_q, rgb_b_q;

   // Full duty is forced on so MAX never shows a dark slot at pwm_cnt == MAX.
   assign lit_r = (duty_r == DutyMax) || (pwm_cnt_q < duty_r);
   assign lit_g = (duty_g == DutyMax) || (pwm_cnt_q < duty_g);
   assign lit_b = (duty_b == DutyMax) || (pwm_cnt_q < duty_b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt_q <= '0;
         rgb_r_q   <= 1'b1;
         rgb_g_q   <= 1'b1;
         rgb_b_q   <= 1'b1;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
         rgb_r_q   <= ~lit_r;
         rgb_g_q   <= ~lit_g;
         rgb_b_q   <= ~lit_b;
      end
   end

   assign RGB_R = rgb_r_q;
   assign RGB_G = rgb_g_q;
   assign RGB_B = rgb_b_q;

endmodule

// File: tb/tb_rgb_sequencer_pwm.sv
// Directed bench for rgb_sequencer_pwm with small parameters:
// STEP_CYCLES=10, FADE_TICK=2, PWM_BITS=3, DEBOUNCE_CYCLES=4.
// Cycle k means the negedge after the k-th posedge following reset release.
// Pins are compared as {RGB_R, RGB_G, RGB_B}, active-low.

module tb_rgb_sequencer_pwm;

   localparam logic [2:0] Off = 3'b111;
   localparam logic [2:0] Red = 3'b011;
   localparam logic [2:0] Yel = 3'b001;
   localparam logic [2:0] Grn = 3'b101;
   localparam logic [2:0] Cya = 3'b100;
   localparam logic [2:0] Blu = 3'b110;
   localparam logic [2:0] Pur = 3'b010;

   logic clk;
   logic rst_n;
   logic boot;
   logic sw;
   logic rgb_r, rgb_g, rgb_b;
   logic [2:0] pins;

   int n_cmp;
   int n_err;
   int cyc;

   assign pins = {rgb_r, rgb_g, rgb_b};

   rgb_sequencer_pwm #(
      .STEP_CYCLES     (10),
      .FADE_TICK       (2),
      .PWM_BITS        (3),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .BOOT  (boot),
      .SW    (sw),
      .RGB_R (rgb_r),
      .RGB_G (rgb_g),
      .RGB_B (rgb_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      boot  = 1'b1;
      sw    = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("reset_pins", 32'(pins), 32'(Off));
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   // Press acts on the 6th posedge after the drive, then 8 cycles of release.
   task automatic press_boot;
      boot = 1'b0;
      adv(6);
      boot = 1'b1;
      adv(8);
   endtask

   task automatic press_sw;
      sw = 1'b0;
      adv(6);
      sw = 1'b1;
      adv(8);
   endtask

   initial begin
      int r_lit, g_lit, b_lit;
      n_cmp = 0;
      n_err = 0;
      cyc   = 0;
      rst_n = 1'b0;
      boot  = 1'b1;
      sw    = 1'b1;

      // 1: free-running STEP sequence
      do_reset;
      adv(1);  check_eq("t1_c1_red",  32'(pins), 32'(Red));
      adv(9);  check_eq("t1_c10_red", 32'(pins), 32'(Red));
      adv(1);  check_eq("t1_c11_yel", 32'(pins), 32'(Yel));
      adv(10); check_eq("t1_c21_grn", 32'(pins), 32'(Grn));
      adv(10); check_eq("t1_c31_cya", 32'(pins), 32'(Cya));
      adv(10); check_eq("t1_c41_blu", 32'(pins), 32'(Blu));
      adv(10); check_eq("t1_c51_pur", 32'(pins), 32'(Pur));
      adv(9);  check_eq("t1_c60_pur", 32'(pins), 32'(Pur));
      adv(1);  check_eq("t1_c61_red", 32'(pins), 32'(Red));

      // 2: 3-cycle glitch ignored; 6-cycle press pauses at E16, resume at E66
      do_reset;
      boot = 1'b0; adv(3); boot = 1'b1;
      adv(7);  check_eq("t2_c10_red", 32'(pins), 32'(Red));
      boot = 1'b0;
      adv(1);  check_eq("t2_c11_yel", 32'(pins), 32'(Yel));
      adv(5);  boot = 1'b1;
      adv(44); check_eq("t2_c60_hold", 32'(pins), 32'(Yel));
      boot = 1'b0; adv(6); boot = 1'b1;
      adv(4);  check_eq("t2_c70_hold", 32'(pins), 32'(Yel));
      adv(1);  check_eq("t2_c71_grn",  32'(pins), 32'(Grn));
      adv(9);  check_eq("t2_c80_grn",  32'(pins), 32'(Grn));
      adv(1);  check_eq("t2_c81_cya",  32'(pins), 32'(Cya));

      // 3: FADE entered at E6; pause with ramp=3 at E13, resume at E27
      do_reset;
      sw = 1'b0; adv(6); sw = 1'b1;
      adv(1);  check_eq("t3_c7_r0", 32'(pins), 32'(Red));
      boot = 1'b0; adv(6); boot = 1'b1;
      r_lit = 0; g_lit = 0; b_lit = 0;
      for (int i = 0; i < 8; i++) begin
         adv(1);
         if (!rgb_r) r_lit++;
         if (!rgb_g) g_lit++;
         if (!rgb_b) b_lit++;
      end
      check_eq("t3_win_g", 32'(g_lit), 32'd3);
      check_eq("t3_win_r", 32'(r_lit), 32'd8);
      check_eq("t3_win_b", 32'(b_lit), 32'd0);
      boot = 1'b0; adv(6); boot = 1'b1;
      adv(2);  check_eq("t3_c29_g4off", 32'(pins), 32'(Red));
      adv(4);  check_eq("t3_c33_g6on",  32'(pins), 32'(Yel));
      adv(2);  check_eq("t3_c35_g7",    32'(pins), 32'(Yel));
      adv(1);  check_eq("t3_c36_g7",    32'(pins), 32'(Yel));
      adv(5);  check_eq("t3_c41_r5on",  32'(pins), 32'(Yel));
      adv(5);  check_eq("t3_c46_r3off", 32'(pins), 32'(Grn));
      adv(5);  check_eq("t3_c51_r0",    32'(pins), 32'(Grn));

      // 4: MANUAL stepping
      do_reset;
      press_sw;
      press_sw;
      check_eq("t4_man_red", 32'(pins), 32'(Red));
      press_boot; check_eq("t4_man_yel", 32'(pins), 32'(Yel));
      press_boot; check_eq("t4_man_grn", 32'(pins), 32'(Grn));
      press_boot; check_eq("t4_man_cya", 32'(pins), 32'(Cya));
      adv(100);   check_eq("t4_man_idle", 32'(pins), 32'(Cya));
      press_boot; check_eq("t4_man_blu", 32'(pins), 32'(Blu));
      press_boot; check_eq("t4_man_pur", 32'(pins), 32'(Pur));
      press_boot; check_eq("t4_man_wrap", 32'(pins), 32'(Red));

      // 5: SW and BOOT presses in the same cycle (E6): FADE, not paused
      do_reset;
      sw = 1'b0; boot = 1'b0; adv(6); sw = 1'b1; boot = 1'b1;
      adv(1);  check_eq("t5_c7_idx0",  32'(pins), 32'(Red));
      adv(15); check_eq("t5_c22_ramp", 32'(pins), 32'(Yel));
      adv(16); check_eq("t5_c38_seg1", 32'(pins), 32'(Grn));

      // 6: async reset mid-FADE at idx=3, ramp=5
      do_reset;
      sw = 1'b0; adv(6); sw = 1'b1;
      adv(59); check_eq("t6_c65_seg3", 32'(pins), 32'(Cya));
      rst_n = 1'b0;
      #1;
      check_eq("t6_async_off", 32'(pins), 32'(Off));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
      adv(1);  check_eq("t6_c1_red",  32'(pins), 32'(Red));
      adv(9);  check_eq("t6_c10_red", 32'(pins), 32'(Red));
      adv(1);  check_eq("t6_c11_yel", 32'(pins), 32'(Yel));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
